// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled via a shared b_tick strobe.
// Synchronises rx, validates the start bit at mid-bit and samples data/stop at mid-bit.
module uart_rx #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int unsigned TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] MID_BIT   = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [TW-1:0]          tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             sh_q, sh_d;
  logic [7:0]             data_d;
  logic                   done_d, err_d, busy_d;

  // Sync chain presets to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      rx_data   <= data_d;
      rx_done   <= done_d;
      frame_err <= err_d;
      rx_busy   <= busy_d;
    end
  end

  // Next-state and next-output logic; strobes default low so they last one clk.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = rx_data;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          tick_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (b_tick) begin
          if (tick_q == MID_START) begin
            if (!rx_s) begin
              tick_d  = '0;
              bit_d   = '0;
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (b_tick) begin
          if (tick_q == MID_BIT) begin
            sh_d   = {rx_s, sh_q[7:1]};
            tick_d = '0;
            if (bit_q == 3'd7) state_d = S_STOP;
            else               bit_d   = bit_q + 3'd1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_STOP: begin
        if (b_tick) begin
          if (tick_q == MID_BIT) begin
            state_d = S_IDLE;
            if (rx_s) begin
              data_d = sh_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule
